// File: rtl/game_select_ctrl.sv
// game_select_ctrl: setup/move controller for the flood-it game.
// Turns debounced buttons and colour switches into board-setting edits, the
// board-initialise and begin-game handshakes, and one colour-move pulse per
// accepted switch toggle. The try budget is derived arithmetically from the
// size and colour count in play.
// Optional feature: define SELECT_TRY_LIMIT_EN to refuse moves once the try
// budget is used up and to end the game with GAME_OVER.
module game_select_ctrl #(
    parameter int NUM_SW       = 8,
    parameter int COLOR_MIN    = 3,
    parameter int COLOR_DEF    = 6,
    parameter int SIZE_MIN     = 2,
    parameter int SIZE_MAX     = 26,
    parameter int SIZE_STEP    = 4,
    parameter int SIZE_DEF     = 14,
    parameter int TRIES_W      = 8,
    parameter int BUDGET_NUM   = 11,
    parameter int BUDGET_SHIFT = 5
) (
    input  logic                              MASTER_CLOCK,
    input  logic                              RESET_N,
    input  logic                              UP,
    input  logic                              DOWN,
    input  logic                              LEFT,
    input  logic                              RIGHT,
    input  logic                              CENTER,
    input  logic [NUM_SW-1:0]                 sw,
    output logic                              INITIALIZE_BOARD,
    input  logic                              BOARD_READY,
    output logic                              BEGIN_GAME,
    input  logic                              ACK_BEGIN_GAME,
    output logic                              COLOR_SEL_SIG,
    output logic [$clog2(NUM_SW)-1:0]         COLOR_SELECTED,
    input  logic                              CURRENTLY_CHANGING_COLOR,
    input  logic                              BOARD_SOLVED,
    output logic [$clog2(SIZE_MAX+1)-1:0]     SIZE,
    output logic [$clog2(SIZE_MAX+1)-1:0]     final_SIZE,
    output logic [$clog2(NUM_SW+1)-1:0]       COLOR_NUM,
    output logic [$clog2(NUM_SW+1)-1:0]       final_COLOR_NUM,
    output logic                              sORc,
    output logic                              MODE,
    output logic [TRIES_W-1:0]                TRIES,
    output logic [TRIES_W-1:0]                TOTAL_TRIES,
    output logic                              GAME_OVER
);

    localparam int SW_     = $clog2(SIZE_MAX + 1);
    localparam int CW      = $clog2(NUM_SW + 1);
    localparam int SELW    = $clog2(NUM_SW);
    localparam int PW      = SW_ + CW + $clog2(BUDGET_NUM + 1) + TRIES_W;
    localparam int TRY_MAX = (1 << TRIES_W) - 1;

    localparam int B_DOWN   = 0;
    localparam int B_UP     = 1;
    localparam int B_LEFT   = 2;
    localparam int B_RIGHT  = 3;
    localparam int B_CENTER = 4;

    typedef enum logic [2:0] {
        S_BOOT,
        S_INIT,
        S_BEGIN,
        S_PLAY,
        S_SETUP,
        S_DONE
    } state_t;

    state_t            state;
    logic [NUM_SW-1:0] sw_hist;
    logic [4:0]        btn_now;
    logic [4:0]        btn_hist;
    logic [4:0]        btn_ev;
    logic              move_found;
    logic [SELW-1:0]   move_idx;
    logic              move_allowed;
    logic [TRIES_W-1:0] tries_inc;
    logic [PW-1:0]     product;
    logic [PW-1:0]     scaled;
    logic [TRIES_W-1:0] budget;
    logic [SW_-1:0]    size_up;
    logic [SW_-1:0]    size_down;
    logic [CW-1:0]     color_up;
    logic [CW-1:0]     color_down;

    // A button event is a press seen for the first cycle only.
    assign btn_now = {CENTER, RIGHT, LEFT, UP, DOWN};
    assign btn_ev  = btn_now & ~btn_hist;

    // Saturating try increment.
    assign tries_inc = (TRIES == TRIES_W'(TRY_MAX)) ? TRIES : TRIES + TRIES_W'(1);

`ifdef SELECT_TRY_LIMIT_EN
    assign move_allowed = (TRIES != TOTAL_TRIES);
`else
    assign move_allowed = 1'b1;
`endif

    // Pick the lowest-index toggled switch that is a legal colour in play.
    always_comb begin
        move_found = 1'b0;
        move_idx   = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if ((sw[i] != sw_hist[i]) && (CW'(i) < final_COLOR_NUM)) begin
                move_found = 1'b1;
                move_idx   = SELW'(i);
            end
        end
    end

    // Try budget at full product width, clamped to [1, max try count].
    always_comb begin
        product = PW'(final_SIZE) * PW'(final_COLOR_NUM - CW'(1)) * PW'(BUDGET_NUM);
        scaled  = product >> BUDGET_SHIFT;
        if (scaled == '0) begin
            budget = TRIES_W'(1);
        end else if (scaled > PW'(TRY_MAX)) begin
            budget = TRIES_W'(TRY_MAX);
        end else begin
            budget = scaled[TRIES_W-1:0];
        end
    end

    // Next size/colour values for UP/DOWN, wrapping at either end of the range.
    always_comb begin
        if (SIZE >= SW_'(SIZE_MAX)) begin
            size_up = SW_'(SIZE_MIN);
        end else if (SIZE > SW_'(SIZE_MAX - SIZE_STEP)) begin
            size_up = SW_'(SIZE_MAX);
        end else begin
            size_up = SIZE + SW_'(SIZE_STEP);
        end

        if (SIZE <= SW_'(SIZE_MIN)) begin
            size_down = SW_'(SIZE_MAX);
        end else if (SIZE < SW_'(SIZE_MIN + SIZE_STEP)) begin
            size_down = SW_'(SIZE_MIN);
        end else begin
            size_down = SIZE - SW_'(SIZE_STEP);
        end

        if (COLOR_NUM >= CW'(NUM_SW)) begin
            color_up = CW'(COLOR_MIN);
        end else begin
            color_up = COLOR_NUM + CW'(1);
        end

        if (COLOR_NUM <= CW'(COLOR_MIN)) begin
            color_down = CW'(NUM_SW);
        end else begin
            color_down = COLOR_NUM - CW'(1);
        end
    end

    // Controller FSM with registered outputs and input history registers.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state            <= S_BOOT;
            sw_hist          <= sw;
            btn_hist         <= btn_now;
            INITIALIZE_BOARD <= 1'b0;
            BEGIN_GAME       <= 1'b0;
            COLOR_SEL_SIG    <= 1'b0;
            COLOR_SELECTED   <= '0;
            SIZE             <= SW_'(SIZE_DEF);
            final_SIZE       <= SW_'(SIZE_DEF);
            COLOR_NUM        <= CW'(COLOR_DEF);
            final_COLOR_NUM  <= CW'(COLOR_DEF);
            sORc             <= 1'b0;
            MODE             <= 1'b1;
            TRIES            <= '0;
            TOTAL_TRIES      <= '0;
            GAME_OVER        <= 1'b0;
        end else begin
            sw_hist  <= sw;
            btn_hist <= btn_now;

            if (COLOR_SEL_SIG && CURRENTLY_CHANGING_COLOR) begin
                COLOR_SEL_SIG <= 1'b0;
            end

            case (state)
                S_BOOT: begin
                    INITIALIZE_BOARD <= 1'b1;
                    state            <= S_INIT;
                end

                S_INIT: begin
                    if (BOARD_READY) begin
                        INITIALIZE_BOARD <= 1'b0;
                        BEGIN_GAME       <= 1'b1;
                        TRIES            <= '0;
                        TOTAL_TRIES      <= budget;
                        GAME_OVER        <= 1'b0;
                        state            <= S_BEGIN;
                    end
                end

                S_BEGIN: begin
                    if (ACK_BEGIN_GAME) begin
                        BEGIN_GAME <= 1'b0;
                        MODE       <= 1'b1;
                        state      <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (!COLOR_SEL_SIG && !CURRENTLY_CHANGING_COLOR &&
                        move_found && move_allowed) begin
                        COLOR_SELECTED <= move_idx;
                        COLOR_SEL_SIG  <= 1'b1;
                        TRIES          <= tries_inc;
                    end

                    if (BOARD_SOLVED) begin
                        state <= S_DONE;
`ifdef SELECT_TRY_LIMIT_EN
                    end else if ((TRIES == TOTAL_TRIES) && !COLOR_SEL_SIG) begin
                        GAME_OVER <= 1'b1;
                        state     <= S_DONE;
`endif
                    end else if (btn_ev[B_RIGHT]) begin
                        MODE  <= 1'b0;
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (btn_ev[B_CENTER]) begin
                        final_SIZE       <= SIZE;
                        final_COLOR_NUM  <= COLOR_NUM;
                        INITIALIZE_BOARD <= 1'b1;
                        state            <= S_INIT;
                    end else if (btn_ev[B_RIGHT]) begin
                        MODE  <= 1'b1;
                        state <= S_PLAY;
                    end else if (btn_ev[B_LEFT]) begin
                        sORc <= ~sORc;
                    end else if (btn_ev[B_UP]) begin
                        if (sORc) begin
                            SIZE <= size_up;
                        end else begin
                            COLOR_NUM <= color_up;
                        end
                    end else if (btn_ev[B_DOWN]) begin
                        if (sORc) begin
                            SIZE <= size_down;
                        end else begin
                            COLOR_NUM <= color_down;
                        end
                    end
                end

                S_DONE: begin
                    if (btn_ev[B_CENTER]) begin
                        INITIALIZE_BOARD <= 1'b1;
                        state            <= S_INIT;
                    end else if (btn_ev[B_RIGHT]) begin
                        MODE  <= 1'b0;
                        state <= S_SETUP;
                    end
                end

                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_select_ctrl.sv
// tb_game_select_ctrl: directed bench for game_select_ctrl.
// Accepted moves are pushed to a scoreboard queue when the switch is toggled
// and popped when the DUT raises COLOR_SEL_SIG. Expectations follow
// SELECT_TRY_LIMIT_EN when it is defined for the build.
module tb_game_select_ctrl;

    localparam logic [4:0] BTN_C = 5'b10000;
    localparam logic [4:0] BTN_R = 5'b01000;
    localparam logic [4:0] BTN_L = 5'b00100;
    localparam logic [4:0] BTN_U = 5'b00010;
    localparam logic [4:0] BTN_D = 5'b00001;

    logic       master_clock = 1'b0;
    logic       reset_n;
    logic       up, down, left, right, center;
    logic [7:0] sw;
    logic       board_ready, ack_begin_game, changing, board_solved;

    logic       initialize_board, begin_game, color_sel_sig;
    logic [2:0] color_selected;
    logic [4:0] size, final_size;
    logic [3:0] color_num, final_color_num;
    logic       s_or_c, mode, game_over;
    logic [7:0] tries, total_tries;

    int   test_count = 0;
    int   fail_count = 0;
    int   exp_q[$];
    int   push_count = 0;
    int   rise_count = 0;
    logic sel_prev   = 1'b0;

    int size_exp[4]  = '{18, 22, 26, 2};
    int color_exp[4] = '{5, 4, 3, 8};

    game_select_ctrl dut (
        .MASTER_CLOCK             (master_clock),
        .RESET_N                  (reset_n),
        .UP                       (up),
        .DOWN                     (down),
        .LEFT                     (left),
        .RIGHT                    (right),
        .CENTER                   (center),
        .sw                       (sw),
        .INITIALIZE_BOARD         (initialize_board),
        .BOARD_READY              (board_ready),
        .BEGIN_GAME               (begin_game),
        .ACK_BEGIN_GAME           (ack_begin_game),
        .COLOR_SEL_SIG            (color_sel_sig),
        .COLOR_SELECTED           (color_selected),
        .CURRENTLY_CHANGING_COLOR (changing),
        .BOARD_SOLVED             (board_solved),
        .SIZE                     (size),
        .final_SIZE               (final_size),
        .COLOR_NUM                (color_num),
        .final_COLOR_NUM          (final_color_num),
        .sORc                     (s_or_c),
        .MODE                     (mode),
        .TRIES                    (tries),
        .TOTAL_TRIES              (total_tries),
        .GAME_OVER                (game_over)
    );

    // Free-running clock.
    always #5 master_clock = ~master_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge master_clock);
    endtask

    // One button press: held for one cycle, then released for one cycle.
    task automatic applyStimulus(input logic [4:0] btns);
        {center, right, left, up, down} = btns;
        tick();
        {center, right, left, up, down} = 5'b0;
        tick();
    endtask

    task automatic push_move(input int idx);
        exp_q.push_back(idx);
        push_count++;
    endtask

    // Scoreboard pop: each new move pulse must carry the next expected colour.
    always @(negedge master_clock) begin
        if (color_sel_sig && !sel_prev) begin
            rise_count++;
            if (exp_q.size() != 0) begin
                checkOutput("move_color", 32'(color_selected), 32'(exp_q.pop_front()));
            end
        end
        sel_prev = color_sel_sig;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        reset_n = 1'b0;
        {center, right, left, up, down} = 5'b0;
        sw = 8'h00;
        board_ready = 1'b0; ack_begin_game = 1'b0;
        changing = 1'b0; board_solved = 1'b0;
        tick();
        tick();

        checkOutput("rst_init_board", 32'(initialize_board), 0);
        checkOutput("rst_begin", 32'(begin_game), 0);
        checkOutput("rst_size", 32'(size), 14);
        checkOutput("rst_final_size", 32'(final_size), 14);
        checkOutput("rst_color_num", 32'(color_num), 6);
        checkOutput("rst_final_color", 32'(final_color_num), 6);
        checkOutput("rst_mode", 32'(mode), 1);
        checkOutput("rst_sorc", 32'(s_or_c), 0);
        checkOutput("rst_tries", 32'(tries), 0);
        checkOutput("rst_total", 32'(total_tries), 0);

        // First game: 14 x 5 x 11 = 770 >> 5 = 24 tries.
        reset_n = 1'b1;
        board_ready = 1'b1;
        tick();
        checkOutput("boot_init_board", 32'(initialize_board), 1);
        tick();
        checkOutput("ready_init_low", 32'(initialize_board), 0);
        checkOutput("ready_begin_high", 32'(begin_game), 1);
        checkOutput("budget_24", 32'(total_tries), 24);
        board_ready = 1'b0;
        ack_begin_game = 1'b1;
        tick();
        ack_begin_game = 1'b0;
        checkOutput("ack_begin_low", 32'(begin_game), 0);
        checkOutput("play_mode", 32'(mode), 1);

        // Simultaneous toggles of sw[2] and sw[5]: only colour 2 is taken.
        sw[2] = 1'b1; sw[5] = 1'b1;
        push_move(2);
        tick();
        checkOutput("move1_sel", 32'(color_sel_sig), 1);
        checkOutput("move1_tries", 32'(tries), 1);
        changing = 1'b1;
        tick();
        changing = 1'b0;
        checkOutput("move1_clear", 32'(color_sel_sig), 0);

        // sw[7] is outside the six colours in play.
        sw[7] = 1'b1;
        tick();
        checkOutput("sw7_ignored_sel", 32'(color_sel_sig), 0);
        checkOutput("sw7_ignored_tries", 32'(tries), 1);

        // A toggle while a move is still pending is dropped.
        sw[0] = 1'b1;
        push_move(0);
        tick();
        checkOutput("move2_tries", 32'(tries), 2);
        sw[1] = 1'b1;
        changing = 1'b1;
        tick();
        changing = 1'b0;
        checkOutput("move2_clear", 32'(color_sel_sig), 0);
        tick();
        checkOutput("pending_drop_sel", 32'(color_sel_sig), 0);
        checkOutput("pending_drop_tries", 32'(tries), 2);

        // Setup: size 14 -> 18 -> 22 -> 26 -> 2, colours 6 -> 5 -> 4 -> 3 -> 8.
        applyStimulus(BTN_R);
        checkOutput("setup_mode", 32'(mode), 0);
        applyStimulus(BTN_L);
        checkOutput("sorc_size", 32'(s_or_c), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(BTN_U);
            checkOutput("size_up", 32'(size), 32'(size_exp[i]));
        end
        applyStimulus(BTN_L);
        checkOutput("sorc_color", 32'(s_or_c), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(BTN_D);
            checkOutput("color_down", 32'(color_num), 32'(color_exp[i]));
        end
        checkOutput("final_size_held", 32'(final_size), 14);
        applyStimulus(BTN_C);
        checkOutput("center_init", 32'(initialize_board), 1);
        checkOutput("center_final_size", 32'(final_size), 2);
        checkOutput("center_final_color", 32'(final_color_num), 8);
        checkOutput("center_mode_still0", 32'(mode), 0);

        // Second game: 2 x 7 x 11 = 154 >> 5 = 4 tries.
        board_ready = 1'b1;
        tick();
        board_ready = 1'b0;
        checkOutput("budget_4", 32'(total_tries), 4);
        ack_begin_game = 1'b1;
        tick();
        ack_begin_game = 1'b0;
        checkOutput("game2_mode", 32'(mode), 1);
        checkOutput("game2_tries0", 32'(tries), 0);

        // With eight colours in play sw[7] is now a legal move.
        sw[7] = 1'b0;
        push_move(7);
        tick();
        checkOutput("move_sw7_tries", 32'(tries), 1);
        changing = 1'b1;
        tick();
        changing = 1'b0;

        // Colour count 8 wraps up to 3; budget 2 x 2 x 11 = 44 >> 5 = 1.
        applyStimulus(BTN_R);
        applyStimulus(BTN_U);
        checkOutput("color_wrap_up", 32'(color_num), 3);
        applyStimulus(BTN_C);
        checkOutput("final_color_3", 32'(final_color_num), 3);
        board_ready = 1'b1;
        tick();
        board_ready = 1'b0;
        checkOutput("budget_1", 32'(total_tries), 1);
        ack_begin_game = 1'b1;
        tick();
        ack_begin_game = 1'b0;

        // The last allowed move is acknowledged on the same edge as the solve.
        sw[1] = 1'b0;
        push_move(1);
        tick();
        checkOutput("move3_tries", 32'(tries), 1);
        changing = 1'b1;
        board_solved = 1'b1;
        tick();
        changing = 1'b0;
        board_solved = 1'b0;
        checkOutput("solve_game_over", 32'(game_over), 0);
        checkOutput("solve_clear", 32'(color_sel_sig), 0);

        // DONE ignores moves.
        sw[0] = 1'b0;
        tick();
        checkOutput("done_no_move", 32'(color_sel_sig), 0);
        checkOutput("done_tries", 32'(tries), 1);

        // Replay with unchanged settings.
        applyStimulus(BTN_C);
        checkOutput("replay_init", 32'(initialize_board), 1);
        checkOutput("replay_final_size", 32'(final_size), 2);
        checkOutput("replay_final_color", 32'(final_color_num), 3);
        board_ready = 1'b1;
        tick();
        board_ready = 1'b0;
        checkOutput("replay_tries0", 32'(tries), 0);
        checkOutput("replay_budget", 32'(total_tries), 1);
        ack_begin_game = 1'b1;
        tick();
        ack_begin_game = 1'b0;

        // One move uses the single try; a second toggle follows.
        sw[2] = 1'b0;
        push_move(2);
        tick();
        checkOutput("move4_tries", 32'(tries), 1);
        changing = 1'b1;
        tick();
        changing = 1'b0;
        sw[0] = 1'b1;
`ifdef SELECT_TRY_LIMIT_EN
        tick();
        checkOutput("limit_refused_sel", 32'(color_sel_sig), 0);
        checkOutput("limit_refused_tries", 32'(tries), 1);
        checkOutput("limit_game_over", 32'(game_over), 1);
        applyStimulus(BTN_C);
`else
        push_move(0);
        tick();
        checkOutput("unlimited_sel", 32'(color_sel_sig), 1);
        checkOutput("unlimited_tries", 32'(tries), 2);
        checkOutput("unlimited_game_over", 32'(game_over), 0);
        changing = 1'b1;
        tick();
        changing = 1'b0;
        applyStimulus(BTN_R);
        applyStimulus(BTN_C);
`endif
        checkOutput("pre_reset_init", 32'(initialize_board), 1);

        // Asynchronous reset mid-handshake.
        reset_n = 1'b0;
        #1;
        checkOutput("async_init_low", 32'(initialize_board), 0);
        checkOutput("async_begin_low", 32'(begin_game), 0);
        checkOutput("async_sel_low", 32'(color_sel_sig), 0);
        checkOutput("async_final_size", 32'(final_size), 14);
        checkOutput("async_final_color", 32'(final_color_num), 6);
        checkOutput("async_mode", 32'(mode), 1);
        checkOutput("async_tries", 32'(tries), 0);
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("rearm_init", 32'(initialize_board), 1);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
        checkOutput("move_pulse_count", 32'(rise_count), 32'(push_count));

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
